// File: rtl/netwalk_flow_meter.sv
// Per-flow hit meter: DEPTH valid-qualified saturating counters, program/delete port, registered read port.
// Optional build macro NETWALK_METER_READ_CLEAR_EN turns reads into read-to-clear.
module netwalk_flow_meter #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              glbl_program_en,
  input  logic [ADDR_W-1:0] meter_program_addr,
  input  logic              meter_program_enable,
  input  logic              meter_delete_enable,
  input  logic [ADDR_W-1:0] meter_of_match_addr,
  input  logic              meter_of_match_found,
  output logic [CNT_W-1:0]  meter_count,
  output logic              meter_count_valid,
  input  logic              meter_read_en,
  input  logic [ADDR_W-1:0] meter_read_addr,
  output logic [CNT_W-1:0]  meter_read_data
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic [CNT_W-1:0] meter_count_q;
  logic             meter_count_valid_q;
  logic [CNT_W-1:0] meter_read_data_q;

  logic             ctl_en;
  logic             ctl_hits_match;
  logic             hit;
  logic [CNT_W-1:0] hit_base;
  logic [CNT_W-1:0] hit_val;
  logic [CNT_W-1:0] rd_val;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_ONE;
  endfunction

  always_comb begin
    ctl_en         = meter_program_enable | meter_delete_enable;
    ctl_hits_match = ctl_en && (meter_program_addr == meter_of_match_addr);
    hit            = meter_of_match_found && !glbl_program_en &&
                     valid_q[meter_of_match_addr] && !ctl_hits_match;
`ifdef NETWALK_METER_READ_CLEAR_EN
    // A same-address read clears first, so the concurrent hit counts from zero.
    if (meter_read_en && (meter_read_addr == meter_of_match_addr))
      hit_base = '0;
    else
      hit_base = cnt_q[meter_of_match_addr];
`else
    hit_base = cnt_q[meter_of_match_addr];
`endif
    hit_val = sat_inc(hit_base);
    rd_val  = valid_q[meter_read_addr] ? cnt_q[meter_read_addr] : '0;
  end

  // Priority, lowest to highest: read-clear, hit, program, delete.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) cnt_d[i] = cnt_q[i];
`ifdef NETWALK_METER_READ_CLEAR_EN
    if (meter_read_en) cnt_d[meter_read_addr] = '0;
`endif
    if (hit) cnt_d[meter_of_match_addr] = hit_val;
    if (meter_program_enable) begin
      valid_d[meter_program_addr] = 1'b1;
      cnt_d[meter_program_addr]   = '0;
    end
    if (meter_delete_enable) begin
      valid_d[meter_program_addr] = 1'b0;
      cnt_d[meter_program_addr]   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q             <= '0;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
      meter_count_q       <= '0;
      meter_count_valid_q <= 1'b0;
      meter_read_data_q   <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
      meter_count_valid_q <= hit;
      if (hit) meter_count_q <= hit_val;
      if (meter_read_en) meter_read_data_q <= rd_val;
    end
  end

  assign meter_count       = meter_count_q;
  assign meter_count_valid = meter_count_valid_q;
  assign meter_read_data   = meter_read_data_q;

endmodule

// File: tb/tb_netwalk_flow_meter.sv
// Directed table-driven bench for netwalk_flow_meter, plus reset-mid-operation and saturation sequences.
module tb_netwalk_flow_meter;

`ifdef NETWALK_METER_READ_CLEAR_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        glbl_program_en = 1'b0;
  logic [5:0]  meter_program_addr = '0;
  logic        meter_program_enable = 1'b0;
  logic        meter_delete_enable = 1'b0;
  logic [5:0]  meter_of_match_addr = '0;
  logic        meter_of_match_found = 1'b0;
  logic        meter_read_en = 1'b0;
  logic [5:0]  meter_read_addr = '0;

  logic [31:0] meter_count, meter_read_data;
  logic        meter_count_valid;
  logic [1:0]  s_count, s_read_data;
  logic        s_count_valid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  netwalk_flow_meter #(.ADDR_W(6), .DEPTH(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .glbl_program_en(glbl_program_en),
    .meter_program_addr(meter_program_addr), .meter_program_enable(meter_program_enable),
    .meter_delete_enable(meter_delete_enable), .meter_of_match_addr(meter_of_match_addr),
    .meter_of_match_found(meter_of_match_found), .meter_count(meter_count),
    .meter_count_valid(meter_count_valid), .meter_read_en(meter_read_en),
    .meter_read_addr(meter_read_addr), .meter_read_data(meter_read_data)
  );

  // Narrow-counter instance so saturation is reachable with a handful of hits.
  netwalk_flow_meter #(.ADDR_W(6), .DEPTH(64), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .glbl_program_en(glbl_program_en),
    .meter_program_addr(meter_program_addr), .meter_program_enable(meter_program_enable),
    .meter_delete_enable(meter_delete_enable), .meter_of_match_addr(meter_of_match_addr),
    .meter_of_match_found(meter_of_match_found), .meter_count(s_count),
    .meter_count_valid(s_count_valid), .meter_read_en(meter_read_en),
    .meter_read_addr(meter_read_addr), .meter_read_data(s_read_data)
  );

  typedef struct {
    logic        pe, de;
    logic [5:0]  pa;
    logic        gp, mf;
    logic [5:0]  ma;
    logic        re;
    logic [5:0]  ra;
    logic        cv;
    logic [31:0] cnt, rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic pe, input logic de, input logic [5:0] pa,
                              input logic gp, input logic mf, input logic [5:0] ma,
                              input logic re, input logic [5:0] ra,
                              input logic cv, input logic [31:0] cnt, input logic [31:0] rd);
    vec_t v;
    v.pe = pe; v.de = de; v.pa = pa; v.gp = gp; v.mf = mf; v.ma = ma;
    v.re = re; v.ra = ra; v.cv = cv; v.cnt = cnt; v.rd = rd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    meter_program_enable = v.pe;
    meter_delete_enable  = v.de;
    meter_program_addr   = v.pa;
    glbl_program_en      = v.gp;
    meter_of_match_found = v.mf;
    meter_of_match_addr  = v.ma;
    meter_read_en        = v.re;
    meter_read_addr      = v.ra;
  endtask

  task automatic idle();
    meter_program_enable = 1'b0;
    meter_delete_enable  = 1'b0;
    glbl_program_en      = 1'b0;
    meter_of_match_found = 1'b0;
    meter_read_en        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // pe de pa gp mf ma re ra | cv cnt rd
    add(1,0,0, 0,0,0, 0,0, 0,0,0);
    add(1,0,1, 0,0,0, 0,0, 0,0,0);
    add(1,0,2, 0,0,0, 0,0, 0,0,0);
    add(0,0,0, 0,0,0, 1,0, 0,0,0);
    add(0,0,0, 0,0,0, 1,1, 0,0,0);
    add(0,0,0, 0,0,0, 1,2, 0,0,0);
    for (int k = 1; k <= 10; k++) add(0,0,0, 0,1,0, 0,0, 1,k,0);
    add(0,0,0, 0,0,0, 1,1, 0,10,0);
    add(0,0,0, 0,0,0, 1,0, 0,10,10);
    for (int k = 0; k < 3; k++) add(0,0,0, 0,1,5, 0,0, 0,10,10);
    add(0,0,0, 0,0,0, 1,5, 0,10,0);
    add(0,1,0, 0,0,0, 0,0, 0,10,0);
    add(0,0,0, 0,1,0, 0,0, 0,10,0);
    add(0,0,0, 0,0,0, 1,0, 0,10,0);
    add(1,0,0, 0,0,0, 0,0, 0,10,0);
    add(0,0,0, 0,1,0, 0,0, 1,1,0);
    for (int k = 0; k < 4; k++) add(0,0,0, 1,1,1, 0,0, 0,1,0);
    add(0,0,0, 0,0,0, 1,1, 0,1,0);
    add(1,0,0, 0,1,0, 0,0, 0,1,0);
    add(0,0,0, 0,0,0, 1,0, 0,1,0);
    add(0,0,0, 0,1,0, 0,0, 1,1,0);
    add(0,1,1, 0,1,1, 0,0, 0,1,0);
    add(0,0,0, 0,0,0, 1,1, 0,1,0);
    add(1,1,2, 0,0,0, 0,0, 0,1,0);
    add(0,0,0, 0,1,2, 0,0, 0,1,0);
    add(1,0,2, 0,0,0, 0,0, 0,1,0);
    add(0,0,0, 0,1,0, 1,0, 1, RC ? 32'd1 : 32'd2, 1);
    add(0,0,0, 0,1,0, 0,0, 1, RC ? 32'd2 : 32'd3, 1);
    add(0,0,0, 0,0,0, 1,0, 0, RC ? 32'd2 : 32'd3, RC ? 32'd2 : 32'd3);
    add(0,0,0, 0,0,0, 1,0, 0, RC ? 32'd2 : 32'd3, RC ? 32'd0 : 32'd3);

    #1 reset = 1'b1;
    #2;
    chk("reset.cnt", meter_count, 32'd0);
    chk("reset.cv", {31'd0, meter_count_valid}, 32'd0);
    chk("reset.rd", meter_read_data, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("row%0d.cv", i), {31'd0, meter_count_valid}, {31'd0, vecs[i].cv});
      chk($sformatf("row%0d.cnt", i), meter_count, vecs[i].cnt);
      chk($sformatf("row%0d.rd", i), meter_read_data, vecs[i].rd);
    end
    idle();

    // Asynchronous reset in the middle of a cycle with a hit in flight.
    meter_of_match_found = 1'b1;
    meter_of_match_addr  = 6'd0;
    #2 reset = 1'b1;
    #1;
    chk("midrst.cnt", meter_count, 32'd0);
    chk("midrst.cv", {31'd0, meter_count_valid}, 32'd0);
    chk("midrst.rd", meter_read_data, 32'd0);
    tick();
    idle();
    reset = 1'b0;
    meter_of_match_found = 1'b1;
    meter_of_match_addr  = 6'd0;
    tick();
    chk("postrst.cv", {31'd0, meter_count_valid}, 32'd0);
    idle();
    meter_read_en = 1'b1;
    meter_read_addr = 6'd0;
    tick();
    chk("postrst.rd", meter_read_data, 32'd0);
    idle();

    // Saturation on the 2-bit instance: 1, 2, then all-ones twice.
    meter_program_enable = 1'b1;
    meter_program_addr   = 6'd2;
    tick();
    idle();
    for (int k = 1; k <= 4; k++) begin
      meter_of_match_found = 1'b1;
      meter_of_match_addr  = 6'd2;
      tick();
      chk($sformatf("sat%0d.cv", k), {31'd0, s_count_valid}, 32'd1);
      chk($sformatf("sat%0d.cnt", k), {30'd0, s_count}, (k >= 3) ? 32'd3 : k);
      chk($sformatf("wide%0d.cnt", k), meter_count, k);
    end
    idle();
    meter_read_en = 1'b1;
    meter_read_addr = 6'd2;
    tick();
    chk("sat.rd", {30'd0, s_read_data}, 32'd3);
    chk("wide.rd", meter_read_data, 32'd4);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
